// File: rtl/bus_arb.sv
// rtl/bus_arb.sv - two-master round-robin bus arbiter with no-ack watchdog
//
// Purpose: shares one stb/we/addr/data/ack bus between master 0 (CPU) and
// master 1 (DMA peripheral), one whole transaction at a time. A watchdog ends
// any transaction that sees no ack within TMO_CYCLES strobe cycles.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   m0_* / m1_*                   master strobe, write enable, word address,
//                                 write data in; read data and ack out
//   bus_stb/we/addr/dout          request towards decoder and slaves
//   bus_din/bus_ack               read data and ack from the ack/data mux
//   bus_tmo                       one-cycle pulse on forced termination
//   tmo_addr                      address of the most recent timeout

module bus_arb #(
  parameter int unsigned TMO_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [29:0] m0_addr,
  input  logic [31:0] m0_dout,
  output logic [31:0] m0_din,
  output logic        m0_ack,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [29:0] m1_addr,
  input  logic [31:0] m1_dout,
  output logic [31:0] m1_din,
  output logic        m1_ack,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [29:0] bus_addr,
  output logic [31:0] bus_dout,
  input  logic [31:0] bus_din,
  input  logic        bus_ack,
  output logic        bus_tmo,
  output logic [29:0] tmo_addr
);

  localparam int unsigned CW = $clog2(TMO_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TMO_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OWN0,
    S_OWN1
  } state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [29:0]   tmo_addr_q, tmo_addr_d;

  // Signals of whichever master currently owns the bus.
  logic        own_sel;
  logic        own_stb;
  logic        own_we;
  logic [29:0] own_addr;
  logic [31:0] own_dout;
  logic        timeout;
  logic        own_ack;

  assign own_sel  = (state_q == S_OWN1);
  assign own_stb  = own_sel ? m1_stb  : m0_stb;
  assign own_we   = own_sel ? m1_we   : m0_we;
  assign own_addr = own_sel ? m1_addr : m0_addr;
  assign own_dout = own_sel ? m1_dout : m0_dout;

  // A real ack in the final cycle beats the watchdog.
  assign timeout  = own_stb && !bus_ack && (cnt_q == CNT_LAST);
  // Reset in flight aborts the transaction without acking the owner.
  assign own_ack  = own_stb && (bus_ack || timeout) && !rst;

  assign tmo_addr = tmo_addr_q;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    tmo_addr_d = tmo_addr_q;
    bus_stb    = 1'b0;
    bus_we     = 1'b0;
    bus_addr   = '0;
    bus_dout   = '0;
    m0_ack     = 1'b0;
    m1_ack     = 1'b0;
    m0_din     = bus_din;
    m1_din     = bus_din;
    bus_tmo    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Master 0 wins alone, or on a tie when master 1 had the last grant.
        if (m0_stb && (!m1_stb || last_q)) begin
          state_d = S_OWN0;
          last_d  = 1'b0;
          cnt_d   = '0;
        end else if (m1_stb) begin
          state_d = S_OWN1;
          last_d  = 1'b1;
          cnt_d   = '0;
        end
      end

      S_OWN0, S_OWN1: begin
        bus_stb  = own_stb;
        bus_we   = own_we;
        bus_addr = own_addr;
        bus_dout = own_dout;
        if (own_sel) begin
          m1_ack = own_ack;
        end else begin
          m0_ack = own_ack;
        end

        if (timeout) begin
          if (own_sel) begin
            m1_din = '0;
          end else begin
            m0_din = '0;
          end
          bus_tmo    = !rst;
          tmo_addr_d = own_addr;
        end

        // Ack, watchdog or withdrawal all release the bus for a dead cycle.
        if (!own_stb || bus_ack || timeout) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      tmo_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      tmo_addr_q <= tmo_addr_d;
    end
  end

endmodule

// File: tb/tb_bus_arb.sv
// tb/tb_bus_arb.sv - bench for bus_arb: directed scenarios plus random traffic

module tb_bus_arb;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_stb, m0_we, m1_stb, m1_we;
  logic [29:0] m0_addr, m1_addr;
  logic [31:0] m0_dout, m1_dout;
  logic [31:0] m0_din, m1_din;
  logic        m0_ack, m1_ack;
  logic        bus_stb, bus_we;
  logic [29:0] bus_addr;
  logic [31:0] bus_dout;
  logic [31:0] bus_din;
  logic        bus_ack;
  logic        bus_tmo;
  logic [29:0] tmo_addr;

  bus_arb #(.TMO_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr), .m0_dout(m0_dout),
    .m0_din(m0_din), .m0_ack(m0_ack),
    .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr), .m1_dout(m1_dout),
    .m1_din(m1_din), .m1_ack(m1_ack),
    .bus_stb(bus_stb), .bus_we(bus_we), .bus_addr(bus_addr), .bus_dout(bus_dout),
    .bus_din(bus_din), .bus_ack(bus_ack),
    .bus_tmo(bus_tmo), .tmo_addr(tmo_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: who holds the bus (-1 none), who was granted last,
  // how many cycles (1-based) the current owner has held it, last timeout address.
  int          own = -1;
  int          lastm = 1;
  int          age = 0;
  logic [29:0] mtmo = '0;
  logic        exp_ack0, exp_ack1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic owner_stb();
    return (own == 1) ? m1_stb : (own == 0) ? m0_stb : 1'b0;
  endfunction

  function automatic logic owner_timeout();
    return (own >= 0) && owner_stb() && !bus_ack && (age == TMO);
  endfunction

  // Wait to the falling edge and compare every output with the model.
  task automatic settle();
    logic xs, to, ackx;
    @(negedge clk);
    xs   = owner_stb();
    to   = owner_timeout();
    ackx = (own >= 0) && xs && (bus_ack || to) && !rst;
    exp_ack0 = (own == 0) && ackx;
    exp_ack1 = (own == 1) && ackx;
    if (own < 0) begin
      chk("idle_stb", bus_stb, 0);
      chk("idle_we", bus_we, 0);
      chk("idle_addr", bus_addr, 0);
      chk("idle_dout", bus_dout, 0);
      chk("idle_tmo", bus_tmo, 0);
    end else begin
      chk("own_stb", bus_stb, xs);
      chk("own_we", bus_we, (own == 1) ? m1_we : m0_we);
      chk("own_addr", bus_addr, (own == 1) ? m1_addr : m0_addr);
      chk("own_dout", bus_dout, (own == 1) ? m1_dout : m0_dout);
      chk("own_tmo", bus_tmo, to && !rst);
      if (ackx) chk("own_din", (own == 1) ? m1_din : m0_din, to ? 32'h0 : bus_din);
    end
    chk("m0_ack", m0_ack, exp_ack0);
    chk("m1_ack", m1_ack, exp_ack1);
    chk("tmo_addr", tmo_addr, mtmo);
  endtask

  // Rising edge: advance the model from the rules, then step off the edge.
  task automatic tick();
    logic xs, to;
    int g;
    @(posedge clk);
    xs = owner_stb();
    to = owner_timeout();
    if (rst) begin
      own = -1; lastm = 1; age = 0; mtmo = '0;
    end else if (own < 0) begin
      if (m0_stb || m1_stb) begin
        g = (m0_stb && m1_stb) ? 1 - lastm : (m0_stb ? 0 : 1);
        own = g; lastm = g; age = 1;
      end
    end else begin
      if (to) mtmo = (own == 1) ? m1_addr : m0_addr;
      if (!xs || bus_ack || to) own = -1;
      else age++;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1;
    m0_stb = 0; m0_we = 0; m0_addr = '0; m0_dout = '0;
    m1_stb = 0; m1_we = 0; m1_addr = '0; m1_dout = '0;
    bus_din = '0; bus_ack = 0;

    // Reset state
    settle();
    chk("rst_stb", bus_stb, 0);
    chk("rst_tmo_addr", tmo_addr, 0);
    tick();
    rst = 1'b0;

    // Single master read, slave acks on the 4th owned cycle
    m0_stb = 1; m0_addr = 30'h0800_0000;
    settle(); chk("rd_latency", bus_stb, 0); tick();
    for (int i = 1; i <= 4; i++) begin
      bus_ack = (i == 4);
      bus_din = (i == 4) ? 32'hDEAD_BEEF : 32'h0;
      settle();
      chk("rd_stb", bus_stb, 1);
      chk("rd_ack", m0_ack, i == 4);
      chk("rd_m1_ack", m1_ack, 0);
      if (i == 4) chk("rd_data", m0_din, 32'hDEAD_BEEF);
      tick();
    end
    m0_stb = 0; bus_ack = 0;
    settle(); chk("rd_release", bus_stb, 0); tick();

    // Timeout on unmapped address
    m0_stb = 1; m0_addr = 30'h0C40_0000;
    settle(); tick();
    for (int i = 1; i <= TMO; i++) begin
      settle();
      chk("to_ack", m0_ack, i == TMO);
      chk("to_pulse", bus_tmo, i == TMO);
      if (i == TMO) chk("to_din", m0_din, 32'h0);
      tick();
    end
    m0_stb = 0;
    settle(); chk("to_addr", tmo_addr, 30'h0C40_0000); chk("to_pulse_end", bus_tmo, 0); tick();

    // Ack on the final cycle wins over the watchdog
    m0_stb = 1; m0_addr = 30'h0C40_0001;
    settle(); tick();
    for (int i = 1; i <= TMO; i++) begin
      bus_ack = (i == TMO);
      bus_din = 32'hCAFE_F00D;
      settle();
      chk("race_tmo", bus_tmo, 0);
      chk("race_ack", m0_ack, i == TMO);
      if (i == TMO) chk("race_din", m0_din, 32'hCAFE_F00D);
      tick();
    end
    m0_stb = 0; bus_ack = 0;
    settle(); chk("race_addr", tmo_addr, 30'h0C40_0000); tick();

    // Simultaneous requests alternate 0,1,0,1 after reset
    rst = 1; settle(); tick(); rst = 0;
    m0_stb = 1; m1_stb = 1; m0_addr = 30'h111; m1_addr = 30'h222; bus_ack = 1;
    for (int g = 0; g < 4; g++) begin
      settle(); chk("rr_gap", bus_stb, 0); tick();
      settle();
      chk("rr_m0", m0_ack, g % 2 == 0);
      chk("rr_m1", m1_ack, g % 2 == 1);
      chk("rr_addr", bus_addr, (g % 2 == 1) ? 30'h222 : 30'h111);
      tick();
    end

    // Write routing from master 1 while master 0 waits
    m0_stb = 0; m1_stb = 0; bus_ack = 0;
    settle(); tick();
    m1_stb = 1; m1_we = 1; m1_dout = 32'h1234_5678;
    settle(); tick();
    m0_stb = 1; m0_dout = 32'h5555_AAAA;
    for (int i = 1; i <= 4; i++) begin
      bus_ack = (i == 4);
      settle();
      chk("wr_we", bus_we, 1);
      chk("wr_dout", bus_dout, 32'h1234_5678);
      chk("wr_m0_ack", m0_ack, 0);
      chk("wr_m1_ack", m1_ack, i == 4);
      tick();
    end
    bus_ack = 0;
    settle(); tick();
    bus_ack = 1;
    settle(); chk("wr_next_owner", bus_addr, 30'h111); chk("wr_next_ack", m0_ack, 1); tick();
    m0_stb = 0; m1_stb = 0; m1_we = 0; bus_ack = 0;
    settle(); tick();

    // Withdrawal: no ack, no timeout, counter restarts on next grant
    m1_stb = 1; m1_addr = 30'h0333;
    settle(); tick();
    for (int i = 0; i < 2; i++) begin settle(); chk("wd_ack", m1_ack, 0); tick(); end
    m1_stb = 0;
    settle(); chk("wd_stb", bus_stb, 0); chk("wd_ack2", m1_ack, 0); chk("wd_tmo", bus_tmo, 0); tick();
    settle(); chk("wd_idle", bus_stb, 0); tick();
    m1_stb = 1;
    settle(); tick();
    for (int i = 1; i <= TMO; i++) begin
      settle(); chk("wd_cnt_tmo", bus_tmo, i == TMO); chk("wd_cnt_ack", m1_ack, i == TMO); tick();
    end
    m1_stb = 0;
    settle(); tick();

    // Reset while master 1 owns the bus
    m1_stb = 1;
    settle(); tick();
    settle(); tick();
    rst = 1; m0_stb = 1;
    settle(); chk("mr_no_ack", m1_ack, 0); tick();
    rst = 0;
    settle(); chk("mr_stb", bus_stb, 0); chk("mr_m1_ack", m1_ack, 0); tick();
    bus_ack = 1;
    settle(); chk("mr_grant", bus_addr, 30'h111); chk("mr_m0_ack", m0_ack, 1); tick();
    m0_stb = 0; m1_stb = 0; bus_ack = 0;
    settle(); tick();

    // Random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      int ack_div;
      ack_div = (c < 750) ? 3 : 12;
      rst = ($urandom_range(0, 199) == 0);
      if (m0_stb) begin
        if ((exp_ack0 && $urandom_range(0, 9) < 6) || $urandom_range(0, 32) == 0) m0_stb = 0;
      end else if ($urandom_range(0, 9) < 3) begin
        m0_stb = 1; m0_we = $urandom_range(0, 1) == 1;
        m0_addr = 30'($urandom()); m0_dout = $urandom();
      end
      if (m1_stb) begin
        if ((exp_ack1 && $urandom_range(0, 9) < 6) || $urandom_range(0, 32) == 0) m1_stb = 0;
      end else if ($urandom_range(0, 9) < 3) begin
        m1_stb = 1; m1_we = $urandom_range(0, 1) == 1;
        m1_addr = 30'($urandom()); m1_dout = $urandom();
      end
      bus_ack = ($urandom_range(0, ack_div - 1) == 0);
      bus_din = $urandom();
      settle();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
